// File: rtl/mul_pkg.sv
// Shared types and constants for the HI/LO shift-add multiplier.
package mul_pkg;
  localparam int DATA_W    = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mul_state_t;
endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Request/result bundle between the issuing pipeline and the HI/LO multiplier.
interface hilo_mult_ctrl_if;
  import mul_pkg::*;
  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, is_signed, rs_val, rt_val, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, rs_val, rt_val, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_step.sv
// One combinational shift-add iteration over the {A,Q} product register.
module mult_step
  import mul_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] a_next,
  output logic [DATA_W-1:0] q_next
);
  logic [DATA_W:0] sum;

  // Carry-out becomes the new MSB of A; the sum LSB shifts into Q.
  assign sum    = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
  assign a_next = sum[DATA_W:1];
  assign q_next = {sum[0], q[DATA_W-1:1]};
endmodule

// File: rtl/hilo_mult_ctrl.sv
// Multi-cycle MULT/MULTU unit owning the HI/LO registers and stall signal.
module hilo_mult_ctrl
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  hilo_mult_ctrl_if.slave   bus
);
  mul_state_t        state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] a_r, q_r, m_r;
  logic              neg;
  logic [DATA_W-1:0] a_nxt, q_nxt;
  logic [DATA_W-1:0] hi_r, lo_r;
  logic              busy_r, done_r;

  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                               input logic sg);
    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    return (sg && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v,
                                                input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  mult_step u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_nxt),
    .q_next (q_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      q_r    <= '0;
      m_r    <= '0;
      neg    <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m_r    <= abs_op(bus.rs_val, bus.is_signed);
            q_r    <= abs_op(bus.rt_val, bus.is_signed);
            a_r    <= '0;
            neg    <= bus.is_signed & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        RUN: begin
          a_r <= a_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MUL_ITERS - 1)) state <= SIGN;
        end
        SIGN: begin
          {hi_r, lo_r} <= neg64({a_r, q_r}, neg);
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl against a 64-bit arithmetic model.
module tb_hilo_mult_ctrl;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  hilo_mult_ctrl_if bus();

  hilo_mult_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start at the next edge; caller is #1 after an edge.
  task automatic issue(input logic sg, input logic [31:0] x, input logic [31:0] y);
    bus.start     = 1'b1;
    bus.is_signed = sg;
    bus.rs_val    = x;
    bus.rt_val    = y;
    tick();
    bus.start     = 1'b0;
    bus.rs_val    = $urandom;
    bus.rt_val    = $urandom;
    bus.is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40 && bus.done !== 1'b1) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 0; bus.is_signed = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic check_op(input string nm, input logic sg, input logic [31:0] x,
                          input logic [31:0] y);
    int cyc;
    logic [63:0] exp;
    exp = ref_prod(sg, x, y);
    issue(sg, x, y);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: busy=%b want 1", nm, bus.busy);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 33) begin
      bad++;
      $display("FAIL %s_latency: cycles=%0d want 33", nm, cyc);
    end
    total++;
    if ({bus.hi, bus.lo} !== exp || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_result: hi=%h lo=%h busy=%b want %h %h busy 0",
               nm, bus.hi, bus.lo, bus.busy, exp[63:32], exp[31:0]);
    end
    tick();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: done=%b want 0", nm, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [63:0] e;
    check_op("multu_7x6", 1'b0, 32'd7, 32'd6);
    total++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_002A) begin
      bad++;
      $display("FAIL const_7x6: got %h%h want 000000000000002a", bus.hi, bus.lo);
    end
    check_op("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5);
    total++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++;
      $display("FAIL const_m3x5: got %h%h want fffffffffffffff1", bus.hi, bus.lo);
    end
    check_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL const_max: got %h%h want fffffffe00000001", bus.hi, bus.lo);
    end
    check_op("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
    e = 64'h4000_0000_0000_0000;
    total++;
    if ({bus.hi, bus.lo} !== e) begin
      bad++;
      $display("FAIL const_min: got %h%h want %h", bus.hi, bus.lo, e);
    end
    check_op("mult_min_x1", 1'b1, 32'h8000_0000, 32'd1);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic sg;
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) x = 32'h8000_0000 | (x & 32'h3);
      if (i % 5 == 0) y = '0;
      sg = $urandom_range(0, 1);
      check_op($sformatf("rand%0d", i), sg, x, y);
    end
  endtask

  task automatic test_mt();
    bus.wdata = 32'h1234_5678;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    total++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mt_both: hi=%h lo=%h want 12345678", bus.hi, bus.lo);
    end
    bus.wdata = 32'hCAFE_0001;
    bus.mtlo = 1'b1;
    tick();
    bus.mtlo = 1'b0;
    total++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL mt_lo_only: hi=%h lo=%h want 12345678 cafe0001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_mt();
    int cyc;
    logic [63:0] exp;
    exp = ref_prod(1'b0, 32'd9, 32'd11);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'd9, 32'd11);
    bus.mtlo = 1'b0;
    total++;
    if (bus.lo !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL start_mt_drop: lo=%h want cafe0001", bus.lo);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 33 || {bus.hi, bus.lo} !== exp) begin
      bad++;
      $display("FAIL start_mt_result: cyc=%0d hi=%h lo=%h want 33 %h", cyc, bus.hi,
               bus.lo, exp);
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    int held_bad;
    logic [63:0] exp;
    logic [31:0] hi0;
    exp = ref_prod(1'b1, 32'hFFFF_FF00, 32'd1234);
    hi0 = bus.hi;
    held_bad = 0;
    issue(1'b1, 32'hFFFF_FF00, 32'd1234);
    for (int c = 1; c < 33; c++) begin
      if (c == 10) begin
        bus.start = 1'b1; bus.is_signed = 1'b0;
        bus.rs_val = 32'd3; bus.rt_val = 32'd3;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h5555_AAAA;
      end
      tick();
      if (c == 10) begin
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      end
      if (bus.hi !== hi0 || bus.done !== 1'b0 || bus.busy !== 1'b1) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++;
      $display("FAIL busy_hold: %0d cycles disturbed, want 0 (hi0=%h)", held_bad, hi0);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 1 || {bus.hi, bus.lo} !== exp) begin
      bad++;
      $display("FAIL busy_ignore_result: extra=%0d hi=%h lo=%h want 1 %h", cyc,
               bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] e1, e2;
    e1 = ref_prod(1'b0, 32'd100, 32'd200);
    e2 = ref_prod(1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    issue(1'b0, 32'd100, 32'd200);
    wait_done(cyc);
    total++;
    if ({bus.hi, bus.lo} !== e1) begin
      bad++;
      $display("FAIL b2b_first: got %h%h want %h", bus.hi, bus.lo, e1);
    end
    issue(1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want 1", bus.busy);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 33 || {bus.hi, bus.lo} !== e2) begin
      bad++;
      $display("FAIL b2b_second: cyc=%0d got %h%h want 33 %h", cyc, bus.hi, bus.lo, e2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    bus.wdata = 32'h0BAD_F00D;
    bus.mthi = 1'b1;
    tick();
    bus.mthi = 1'b0;
    issue(1'b0, 32'hFFFF_0000, 32'h0001_FFFF);
    for (int c = 1; c < 15; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_async: busy=%b hi=%h lo=%h want 0 0 0", bus.busy,
               bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'd0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: %0d bad cycles, want 0", seen);
    end
    issue(1'b0, 32'd3, 32'd4);
    wait_done(cyc);
    total++;
    if (cyc !== 33 || bus.lo !== 32'h0000_000C || bus.hi !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_next: cyc=%0d hi=%h lo=%h want 33 0 c", cyc, bus.hi,
               bus.lo);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_mt();
    test_start_mt();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hilo_mult_ctrl.md
HILO_MULT_CTRL -- requirements
Module: hilo_mult_ctrl

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 start  input  1  Request to begin a multiply; sampled only in IDLE.
REQ-004 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-005 rs_val  input  32  Multiplicand operand; sampled with start.
REQ-006 rt_val  input  32  Multiplier operand; sampled with start.
REQ-007 mthi  input  1  Write wdata into HI; honoured only in IDLE.
REQ-008 mtlo  input  1  Write wdata into LO; honoured only in IDLE.
REQ-009 wdata  input  32  Data for mthi/mtlo.
REQ-010 busy  output  1  High while state is not IDLE; drives the pipeline stall.
REQ-011 done  output  1  One-cycle registered pulse when HI/LO receive a product.
REQ-012 hi  output  32  HI register, upper 32 bits of the last product.
REQ-013 lo  output  32  LO register, lower 32 bits of the last product.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and SIGN.
REQ-015 IDLE SHALL move to RUN on the edge where start=1 (edge E0).
- At E0: capture |rs_val| into M and |rt_val| into Q, taking absolute values only when is_signed=1.
- At E0: clear A; capture neg = is_signed & (rs_val[31] ^ rt_val[31]); clear iteration count.
REQ-016 RUN SHALL perform exactly one shift-add iteration per edge, E1 through E32.
- Each iteration: {c,p} = A + (Q[0] ? M : 0); A <= {c, p[31:1]}; Q <= {p[0], Q[31:1]}.
REQ-017 The iteration counter SHALL be 5 bits and wrap from 31 to 0.
- The transition RUN->SIGN SHALL occur on the edge that completes the 32nd iteration (E32).
REQ-018 SIGN SHALL, at E33, write {hi,lo} <= neg ? -{A,Q} : {A,Q} (64-bit two's complement negate).
- SIGN SHALL return to IDLE at E33 and set done=1 for exactly the following cycle.
REQ-019 Latency: done is high, and the new hi/lo are visible, in the cycle after E33, i.e. 33 cycles after the start edge.
REQ-020 busy SHALL be 1 from the cycle after E0 through the cycle ending at E33; it is 0 in the cycle done is high.
REQ-021 start asserted while busy SHALL be ignored: no restart and no operand capture.
REQ-022 mthi/mtlo asserted while busy SHALL be ignored; hi/lo SHALL hold their values throughout RUN.
REQ-023 In IDLE, mthi and mtlo SHALL update their respective registers at the edge; both asserted together SHALL write wdata to both.
REQ-024 start together with mthi/mtlo in IDLE: start SHALL win and the mt writes SHALL be dropped.
REQ-025 |0x80000000| SHALL be treated as unsigned 0x80000000; no overflow flag exists.
REQ-026 A back-to-back start is accepted at the earliest in the done cycle, since the FSM is then in IDLE.

Reset
REQ-027 Asserting reset SHALL immediately clear the following, including mid-operation:
- state to IDLE; A, Q, M and counter to 0; neg to 0; done, busy, hi and lo to 0.
REQ-028 Deassertion SHALL leave the block in IDLE; no partial product SHALL ever reach hi/lo.

Structure
REQ-029 Shared package mul_pkg SHALL hold the state enum (IDLE, RUN, SIGN) and the constant MUL_ITERS = 32.
REQ-030 The combinational single-iteration datapath SHALL be one sub-module, mult_step (inputs A, Q, M; outputs next A, next Q).
- The remaining logic (FSM, counter, sign handling, HI/LO) SHALL reside in hilo_mult_ctrl.

Verification
REQ-031 MULTU 7 x 6 -> done 33 cycles after start; hi=0x00000000, lo=0x0000002A.
REQ-032 MULT 0xFFFFFFFD x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 Second start and mthi pulses at cycle 10 of a run -> ignored; result still from the first operands; hi unchanged until done.
REQ-035 reset pulsed at cycle 15 of a run -> busy=0, hi=lo=0, no done.
- A following MULTU 3 x 4 -> lo=0x0000000C.
REQ-036 IDLE: mthi and mtlo with wdata=0x12345678 -> hi=lo=0x12345678.
- start+mtlo in the same cycle -> mtlo dropped; product written.
